// File: rtl/decode_pkg.sv
// Shared types for the buffered decode stage: opcode and selector enums,
// the queue entry, the registered decoded bundle and the control word.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN adds an illegal flag to the bundle.
package decode_pkg;

    localparam int DEFAULT_DEPTH = 2;
    localparam int PTR_WIDTH     = $clog2(DEFAULT_DEPTH);
    // Entries always carry a 64-bit pc; narrower configurations zero-extend.
    localparam int PC_WIDTH_MAX  = 64;

    typedef logic [4:0] register_t;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_A_RS1  = 2'd0,
        ALU_A_PC   = 2'd1,
        ALU_A_ZERO = 2'd2
    } alu_operand_a_e;

    typedef enum logic [1:0] {
        ALU_B_RS2 = 2'd0,
        ALU_B_IMM = 2'd1
    } alu_operand_b_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } writeback_source_e;

    typedef struct packed {
        logic [PC_WIDTH_MAX-1:0] pc;
        logic [31:0]             instruction;
    } fetch_entry_t;

    typedef struct packed {
        logic [PC_WIDTH_MAX-1:0] pc;
        register_t               rs1_address;
        register_t               rs2_address;
        register_t               rd_address;
        logic [31:0]             immediate;
        alu_operand_a_e          alu_operand_a_selector;
        alu_operand_b_e          alu_operand_b_selector;
        logic                    jump;
        writeback_source_e       writeback_source_selector;
        logic                    write_enable;
`ifdef DECODE_ILLEGAL_CHECK_EN
        logic                    illegal;
`endif
    } decoded_bundle_t;

    typedef struct packed {
        alu_operand_a_e    alu_operand_a_selector;
        alu_operand_b_e    alu_operand_b_selector;
        logic              jump;
        writeback_source_e writeback_source_selector;
        logic              write_enable;
        logic              early_jump;
    } control_t;

    // True when the 7-bit opcode field names one of the supported opcodes.
    function automatic logic is_known_opcode(input logic [6:0] opcode);
        logic known;
        known = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: known = 1'b1;
            default: known = 1'b0;
        endcase
        return known;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Opcode-driven control decoder: ALU operand selects, jump, writeback source,
// register write enable and the early-jump flag used for JAL redirection.
module control_unit
    import decode_pkg::*;
(
    input  logic [6:0] i_opcode,
    output control_t   o_ctrl
);

    // Map the opcode to its datapath controls; unknown opcodes write nothing.
    always_comb begin
        o_ctrl.alu_operand_a_selector    = ALU_A_RS1;
        o_ctrl.alu_operand_b_selector    = ALU_B_RS2;
        o_ctrl.jump                      = 1'b0;
        o_ctrl.writeback_source_selector = WB_ALU;
        o_ctrl.write_enable              = 1'b0;
        o_ctrl.early_jump                = 1'b0;
        case (i_opcode)
            OPC_LUI: begin
                o_ctrl.alu_operand_a_selector = ALU_A_ZERO;
                o_ctrl.alu_operand_b_selector = ALU_B_IMM;
                o_ctrl.write_enable           = 1'b1;
            end
            OPC_AUIPC: begin
                o_ctrl.alu_operand_a_selector = ALU_A_PC;
                o_ctrl.alu_operand_b_selector = ALU_B_IMM;
                o_ctrl.write_enable           = 1'b1;
            end
            OPC_JAL: begin
                o_ctrl.alu_operand_a_selector    = ALU_A_PC;
                o_ctrl.alu_operand_b_selector    = ALU_B_IMM;
                o_ctrl.jump                      = 1'b1;
                o_ctrl.writeback_source_selector = WB_PC4;
                o_ctrl.write_enable              = 1'b1;
                o_ctrl.early_jump                = 1'b1;
            end
            OPC_JALR: begin
                o_ctrl.alu_operand_b_selector    = ALU_B_IMM;
                o_ctrl.jump                      = 1'b1;
                o_ctrl.writeback_source_selector = WB_PC4;
                o_ctrl.write_enable              = 1'b1;
            end
            OPC_LOAD: begin
                o_ctrl.alu_operand_b_selector    = ALU_B_IMM;
                o_ctrl.writeback_source_selector = WB_MEM;
                o_ctrl.write_enable              = 1'b1;
            end
            OPC_STORE: begin
                o_ctrl.alu_operand_b_selector = ALU_B_IMM;
            end
            OPC_OP_IMM: begin
                o_ctrl.alu_operand_b_selector = ALU_B_IMM;
                o_ctrl.write_enable           = 1'b1;
            end
            OPC_OP: begin
                o_ctrl.write_enable = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/decode_fifo.sv
// Circular queue of fetched entries. The head is read combinationally so it
// can be decoded in the same cycle it is popped. i_clear returns everything to
// zero; i_discard empties the queue by snapping the read pointer to the write pointer.
module decode_fifo
    import decode_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_clear,
    input  logic         i_discard,
    input  fetch_entry_t i_entry,
    output fetch_entry_t o_head,
    output logic         o_empty,
    output logic         o_full
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (PW + 1)'(DEPTH));
    assign o_head  = r_mem[r_rptr];

    // Clear and discard take precedence over ordinary traffic.
    assign w_push = i_push && !o_full && !i_clear && !i_discard;
    assign w_pop  = i_pop && !o_empty && !i_clear && !i_discard;

    // Entry storage: written at the write pointer, no reset needed.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_discard) begin
            r_rptr  <= r_wptr;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/immediate_generator.sv
// Immediate generator: assembles the sign-extended I/S/B/U/J immediate
// selected by the opcode; opcodes without an immediate produce zero.
module immediate_generator
    import decode_pkg::*;
(
    input  logic [31:0] i_instruction,
    output logic [31:0] o_immediate
);

    // Pick the immediate format from the opcode field.
    always_comb begin
        o_immediate = '0;
        case (i_instruction[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:
                o_immediate = {{20{i_instruction[31]}}, i_instruction[31:20]};
            OPC_STORE:
                o_immediate = {{20{i_instruction[31]}}, i_instruction[31:25],
                               i_instruction[11:7]};
            OPC_BRANCH:
                o_immediate = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                               i_instruction[30:25], i_instruction[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                o_immediate = {i_instruction[31:12], 12'h000};
            OPC_JAL:
                o_immediate = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                               i_instruction[20], i_instruction[30:21], 1'b0};
            default:
                o_immediate = '0;
        endcase
    end

endmodule

// File: rtl/decode_queue_stage.sv
// Buffered decode stage: queues fetched {pc, instruction} entries, decodes the
// head and registers the bundle behind a valid/ready handshake. JAL is resolved
// early with a one-cycle redirect that discards the wrong-path entries.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN adds illegal_o.
module decode_queue_stage
    import decode_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int PC_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    fetch_valid_i,
    output logic                    fetch_ready_o,
    input  logic [PC_WIDTH-1:0]     fetch_pc_i,
    input  logic [31:0]             fetch_instruction_i,
    input  logic                    flush_i,
    output logic                    dec_valid_o,
    input  logic                    dec_ready_i,
    output logic [PC_WIDTH-1:0]     dec_pc_o,
    output register_t               rs1_address_o,
    output register_t               rs2_address_o,
    output register_t               rd_address_o,
    output logic [31:0]             immediate_o,
    output alu_operand_a_e          alu_operand_a_selector_o,
    output alu_operand_b_e          alu_operand_b_selector_o,
    output logic                    jump_o,
    output writeback_source_e       writeback_source_selector_o,
    output logic                    write_enable_o,
    output logic                    redirect_valid_o,
    output logic [PC_WIDTH-1:0]     redirect_target_o
`ifdef DECODE_ILLEGAL_CHECK_EN
    ,
    output logic                    illegal_o
`endif
);

    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_load;
    logic                  w_early_jump;
    logic                  w_push;
    logic                  w_illegal;
    control_t              w_ctrl;
    logic [31:0]           w_immediate;
    logic [PC_WIDTH-1:0]   w_target;
    decoded_bundle_t       w_decoded;
    decoded_bundle_t       r_bundle;
    logic                  r_dec_valid;
    logic                  r_redirect_valid;
    logic [PC_WIDTH-1:0]   r_redirect_target;
    logic                  w_unused_pc_bits;

    assign w_push_entry.pc          = PC_WIDTH_MAX'(fetch_pc_i);
    assign w_push_entry.instruction = fetch_instruction_i;

    decode_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_push    (w_push),
        .i_pop     (w_load),
        .i_clear   (flush_i),
        .i_discard (w_early_jump),
        .i_entry   (w_push_entry),
        .o_head    (w_head),
        .o_empty   (w_empty),
        .o_full    (w_full)
    );

    control_unit u_control_unit (
        .i_opcode (w_head.instruction[6:0]),
        .o_ctrl   (w_ctrl)
    );

    immediate_generator u_immediate_generator (
        .i_instruction (w_head.instruction),
        .o_immediate   (w_immediate)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    assign w_illegal = !is_known_opcode(w_head.instruction[6:0])
                       || (w_head.instruction[1:0] != 2'b11);
`else
    assign w_illegal = 1'b0;
`endif

    // While a redirect is in flight, fetch is still on the wrong path.
    assign fetch_ready_o = !w_full && !r_redirect_valid;

    assign w_load       = !w_empty && (!r_dec_valid || dec_ready_i) && !flush_i;
    assign w_early_jump = w_load && w_ctrl.early_jump && !w_illegal;
    // A fetch arriving alongside an early jump is on the wrong path and is dropped.
    assign w_push       = fetch_valid_i && fetch_ready_o && !flush_i && !w_early_jump;

    // Jump target wraps modulo 2^PC_WIDTH.
    assign w_target = w_head.pc[PC_WIDTH-1:0] + PC_WIDTH'($signed(w_immediate));

    // Assemble the decoded bundle for the queue head.
    always_comb begin
        w_decoded                           = '0;
        w_decoded.pc                        = w_head.pc;
        w_decoded.rs1_address               = w_head.instruction[19:15];
        w_decoded.rs2_address               = w_head.instruction[24:20];
        w_decoded.rd_address                = w_head.instruction[11:7];
        w_decoded.immediate                 = w_immediate;
        w_decoded.alu_operand_a_selector    = w_ctrl.alu_operand_a_selector;
        w_decoded.alu_operand_b_selector    = w_ctrl.alu_operand_b_selector;
        w_decoded.jump                      = w_ctrl.jump;
        w_decoded.writeback_source_selector = w_ctrl.writeback_source_selector;
        w_decoded.write_enable              = w_ctrl.write_enable && !w_illegal;
`ifdef DECODE_ILLEGAL_CHECK_EN
        w_decoded.illegal                   = w_illegal;
`endif
    end

    // Output handshake: load on an empty or accepted slot, drain when nothing follows.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dec_valid <= 1'b0;
        end else if (flush_i) begin
            r_dec_valid <= 1'b0;
        end else if (w_load) begin
            r_dec_valid <= 1'b1;
        end else if (r_dec_valid && dec_ready_i) begin
            r_dec_valid <= 1'b0;
        end
    end

    // Bundle payload: changes only on a load, so it is stable under backpressure and flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bundle <= '0;
        end else if (w_load) begin
            r_bundle <= w_decoded;
        end
    end

    // Redirect: one-cycle pulse per early jump; the target holds between jumps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_redirect_valid  <= 1'b0;
            r_redirect_target <= '0;
        end else if (flush_i) begin
            r_redirect_valid  <= 1'b0;
        end else begin
            r_redirect_valid <= w_early_jump;
            if (w_early_jump) begin
                r_redirect_target <= w_target;
            end
        end
    end

    // The stored pc is 64 bits wide; only the low PC_WIDTH bits leave the stage.
    assign w_unused_pc_bits = ^r_bundle.pc;

    assign dec_valid_o                 = r_dec_valid;
    assign dec_pc_o                    = r_bundle.pc[PC_WIDTH-1:0];
    assign rs1_address_o               = r_bundle.rs1_address;
    assign rs2_address_o               = r_bundle.rs2_address;
    assign rd_address_o                = r_bundle.rd_address;
    assign immediate_o                 = r_bundle.immediate;
    assign alu_operand_a_selector_o    = r_bundle.alu_operand_a_selector;
    assign alu_operand_b_selector_o    = r_bundle.alu_operand_b_selector;
    assign jump_o                      = r_bundle.jump;
    assign writeback_source_selector_o = r_bundle.writeback_source_selector;
    assign write_enable_o              = r_bundle.write_enable;
    assign redirect_valid_o            = r_redirect_valid;
    assign redirect_target_o           = r_redirect_target;
`ifdef DECODE_ILLEGAL_CHECK_EN
    assign illegal_o                   = r_bundle.illegal;
`endif

endmodule

// File: tb/tb_decode_queue_stage.sv
// Bench for decode_queue_stage: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the stage.
module tb_decode_queue_stage;
    import decode_pkg::*;

    localparam int DEPTH = 2;
    localparam int PCW   = 32;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              fetch_valid_i = 1'b0;
    logic              fetch_ready_o;
    logic [PCW-1:0]    fetch_pc_i = '0;
    logic [31:0]       fetch_instruction_i = '0;
    logic              flush_i = 1'b0;
    logic              dec_valid_o;
    logic              dec_ready_i = 1'b0;
    logic [PCW-1:0]    dec_pc_o;
    register_t         rs1_address_o, rs2_address_o, rd_address_o;
    logic [31:0]       immediate_o;
    alu_operand_a_e    alu_operand_a_selector_o;
    alu_operand_b_e    alu_operand_b_selector_o;
    logic              jump_o;
    writeback_source_e writeback_source_selector_o;
    logic              write_enable_o;
    logic              redirect_valid_o;
    logic [PCW-1:0]    redirect_target_o;
`ifdef DECODE_ILLEGAL_CHECK_EN
    logic              illegal_o;
`endif

    always #5 clk = ~clk;

    decode_queue_stage #(.DEPTH(DEPTH), .PC_WIDTH(PCW)) dut (
        .clk_i                       (clk),
        .rst_ni                      (rst_ni),
        .fetch_valid_i               (fetch_valid_i),
        .fetch_ready_o               (fetch_ready_o),
        .fetch_pc_i                  (fetch_pc_i),
        .fetch_instruction_i         (fetch_instruction_i),
        .flush_i                     (flush_i),
        .dec_valid_o                 (dec_valid_o),
        .dec_ready_i                 (dec_ready_i),
        .dec_pc_o                    (dec_pc_o),
        .rs1_address_o               (rs1_address_o),
        .rs2_address_o               (rs2_address_o),
        .rd_address_o                (rd_address_o),
        .immediate_o                 (immediate_o),
        .alu_operand_a_selector_o    (alu_operand_a_selector_o),
        .alu_operand_b_selector_o    (alu_operand_b_selector_o),
        .jump_o                      (jump_o),
        .writeback_source_selector_o (writeback_source_selector_o),
        .write_enable_o              (write_enable_o),
        .redirect_valid_o            (redirect_valid_o),
        .redirect_target_o           (redirect_target_o)
`ifdef DECODE_ILLEGAL_CHECK_EN
        ,
        .illegal_o                   (illegal_o)
`endif
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct packed {
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [31:0]       imm;
        alu_operand_a_e    a;
        alu_operand_b_e    b;
        logic              jmp;
        writeback_source_e wb;
        logic              we;
        logic              ill;
    } exp_t;

    // Reference model state: pending entries, output slot, redirect.
    ent_t        m_q[$];
    logic        m_vld = 1'b0;
    logic        m_redir = 1'b0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_ins = '0;
    logic [31:0] m_target = '0;

    // Expected decode of one RV32I instruction word.
    function automatic exp_t dec_model(input logic [31:0] ins);
        exp_t e;
        logic [6:0] op;
        op    = ins[6:0];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.imm = '0;
        e.a   = ALU_A_RS1;
        e.b   = ALU_B_RS2;
        e.jmp = 1'b0;
        e.wb  = WB_ALU;
        e.we  = 1'b0;
        e.ill = !(op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                             7'h37, 7'h63, 7'h67, 7'h6F, 7'h73});
        case (op)
            7'h37: begin e.imm = {ins[31:12], 12'h0}; e.a = ALU_A_ZERO; e.b = ALU_B_IMM; e.we = 1'b1; end
            7'h17: begin e.imm = {ins[31:12], 12'h0}; e.a = ALU_A_PC; e.b = ALU_B_IMM; e.we = 1'b1; end
            7'h6F: begin
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                e.a = ALU_A_PC; e.b = ALU_B_IMM; e.jmp = 1'b1; e.wb = WB_PC4; e.we = 1'b1;
            end
            7'h67: begin e.imm = 32'($signed(ins[31:20])); e.b = ALU_B_IMM; e.jmp = 1'b1; e.wb = WB_PC4; e.we = 1'b1; end
            7'h63: e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            7'h03: begin e.imm = 32'($signed(ins[31:20])); e.b = ALU_B_IMM; e.wb = WB_MEM; e.we = 1'b1; end
            7'h23: begin e.imm = 32'($signed({ins[31:25], ins[11:7]})); e.b = ALU_B_IMM; end
            7'h13: begin e.imm = 32'($signed(ins[31:20])); e.b = ALU_B_IMM; e.we = 1'b1; end
            7'h33: e.we = 1'b1;
            7'h73, 7'h0F: e.imm = 32'($signed(ins[31:20]));
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output with the model.
    task automatic check_all(input string ph);
        exp_t e;
        chk({ph, "/dec_valid"}, 64'(dec_valid_o), 64'(m_vld));
        chk({ph, "/redirect_valid"}, 64'(redirect_valid_o), 64'(m_redir));
        chk({ph, "/fetch_ready"}, 64'(fetch_ready_o), 64'((m_q.size() < DEPTH) && !m_redir));
        chk({ph, "/dec_pc"}, 64'(dec_pc_o), 64'(m_pc));
        chk({ph, "/redirect_target"}, 64'(redirect_target_o), 64'(m_target));
        if (m_vld) begin
            e = dec_model(m_ins);
            chk({ph, "/rs1"}, 64'(rs1_address_o), 64'(e.rs1));
            chk({ph, "/rs2"}, 64'(rs2_address_o), 64'(e.rs2));
            chk({ph, "/rd"}, 64'(rd_address_o), 64'(e.rd));
            chk({ph, "/imm"}, 64'(immediate_o), 64'(e.imm));
            chk({ph, "/alu_a"}, 64'(alu_operand_a_selector_o), 64'(e.a));
            chk({ph, "/alu_b"}, 64'(alu_operand_b_selector_o), 64'(e.b));
            chk({ph, "/jump"}, 64'(jump_o), 64'(e.jmp));
            chk({ph, "/wb_src"}, 64'(writeback_source_selector_o), 64'(e.wb));
`ifdef DECODE_ILLEGAL_CHECK_EN
            chk({ph, "/we"}, 64'(write_enable_o), 64'(e.we && !e.ill));
            chk({ph, "/illegal"}, 64'(illegal_o), 64'(e.ill));
`else
            chk({ph, "/we"}, 64'(write_enable_o), 64'(e.we));
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl, input string ph);
        logic ready, load, ej;
        ent_t h;
        exp_t e;
        fetch_valid_i       = fv;
        fetch_pc_i          = pc;
        fetch_instruction_i = ins;
        dec_ready_i         = rdy;
        flush_i             = fl;
        ready = (m_q.size() < DEPTH) && !m_redir;
        if (m_vld && rdy && !fl)
            $display("[TB] %s deliver pc=%08h ins=%08h", ph, m_pc, m_ins);
        if (fl) begin
            m_q.delete();
            m_vld   = 1'b0;
            m_redir = 1'b0;
        end else begin
            load = (m_q.size() > 0) && (!m_vld || rdy);
            ej   = 1'b0;
            if (load) begin
                h     = m_q.pop_front();
                m_pc  = h.pc;
                m_ins = h.ins;
                m_vld = 1'b1;
                e     = dec_model(h.ins);
                ej    = (h.ins[6:0] == 7'h6F) && !e.ill;
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
            m_redir = ej;
            if (ej) begin
                m_target = h.pc + e.imm;
                m_q.delete();
            end else if (fv && ready) begin
                m_q.push_back('{pc, ins});
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_all(ph);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0]  ops [12];
        logic [31:0] r;
        int          idx;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h00};
        r   = $urandom;
        idx = $urandom_range(0, 11);
        if (idx == 11) return {r[31:7], 7'($urandom)};
        return {r[31:7], ops[idx]};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_vld    = 1'b0;
        m_redir  = 1'b0;
        m_pc     = '0;
        m_ins    = '0;
        m_target = '0;
    endtask

    initial begin
        // Reset
        model_reset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        check_all("reset");
        chk("reset/immediate", 64'(immediate_o), 64'd0);

        // Single addi x5,x0,5: valid two cycles after the handshake
        cycle(1'b1, 32'h100, 32'h00500293, 1'b1, 1'b0, "addi");
        chk("addi/valid_c1", 64'(dec_valid_o), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "addi");
        chk("addi/valid_c2", 64'(dec_valid_o), 64'd1);
        chk("addi/rd", 64'(rd_address_o), 64'd5);
        chk("addi/rs1", 64'(rs1_address_o), 64'd0);
        chk("addi/imm", 64'(immediate_o), 64'd5);
        chk("addi/we", 64'(write_enable_o), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "addi");

        // Backpressure with three entries plus one refused offer
        cycle(1'b1, 32'h200, 32'h00100093, 1'b0, 1'b0, "bp");
        cycle(1'b1, 32'h204, 32'h00200113, 1'b0, 1'b0, "bp");
        cycle(1'b1, 32'h208, 32'h00300193, 1'b0, 1'b0, "bp");
        chk("bp/fetch_ready_full", 64'(fetch_ready_o), 64'd0);
        cycle(1'b1, 32'h20C, 32'h00400213, 1'b0, 1'b0, "bp");
        chk("bp/stable_pc", 64'(dec_pc_o), 64'h200);
        chk("bp/stable_rd", 64'(rd_address_o), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bp");
        chk("bp/order1", 64'(dec_pc_o), 64'h204);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bp");
        chk("bp/order2", 64'(dec_pc_o), 64'h208);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "bp");
        chk("bp/drained", 64'(dec_valid_o), 64'd0);

        // Early jump: jal x1,+8 at 0x100 followed by two wrong-path entries
        cycle(1'b1, 32'h100, 32'h008000EF, 1'b1, 1'b0, "jal");
        cycle(1'b1, 32'h104, 32'h00100093, 1'b1, 1'b0, "jal");
        chk("jal/redirect", 64'(redirect_valid_o), 64'd1);
        chk("jal/target", 64'(redirect_target_o), 64'h108);
        chk("jal/bundle_pc", 64'(dec_pc_o), 64'h100);
        cycle(1'b1, 32'h108, 32'h00200113, 1'b1, 1'b0, "jal");
        chk("jal/pulse_end", 64'(redirect_valid_o), 64'd0);
        repeat (3) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "jal");
            chk("jal/no_wrong_path", 64'(dec_valid_o), 64'd0);
        end

        // Flush with a full queue and a valid bundle
        cycle(1'b1, 32'h300, 32'h00100093, 1'b0, 1'b0, "flush");
        cycle(1'b1, 32'h304, 32'h00200113, 1'b0, 1'b0, "flush");
        cycle(1'b1, 32'h308, 32'h00300193, 1'b0, 1'b0, "flush");
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, "flush");
        chk("flush/valid", 64'(dec_valid_o), 64'd0);
        chk("flush/ready", 64'(fetch_ready_o), 64'd1);
        cycle(1'b1, 32'h400, 32'h00500293, 1'b1, 1'b0, "flush");
        chk("flush/lat_c1", 64'(dec_valid_o), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "flush");
        chk("flush/lat_c2", 64'(dec_valid_o), 64'd1);
        chk("flush/lat_pc", 64'(dec_pc_o), 64'h400);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "flush");

        // Asynchronous reset while two entries are queued
        cycle(1'b1, 32'h500, 32'h00100093, 1'b0, 1'b0, "areset");
        cycle(1'b1, 32'h504, 32'h00200113, 1'b0, 1'b0, "areset");
        cycle(1'b1, 32'h508, 32'h00300193, 1'b0, 1'b0, "areset");
        fetch_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        chk("areset/valid_now", 64'(dec_valid_o), 64'd0);
        chk("areset/redirect_now", 64'(redirect_valid_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        check_all("areset");
        repeat (3) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "areset");

`ifdef DECODE_ILLEGAL_CHECK_EN
        // All-zero word is illegal: no write, no redirect
        cycle(1'b1, 32'h600, 32'h00000000, 1'b1, 1'b0, "illegal");
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "illegal");
        chk("illegal/flag", 64'(illegal_o), 64'd1);
        chk("illegal/we", 64'(write_enable_o), 64'd0);
        chk("illegal/redirect", 64'(redirect_valid_o), 64'd0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "illegal");
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC, rand_ins(),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 29) == 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
